// File: rtl/arb_mux.sv
// N:1 registered multiplexer with a valid/ready handshake on every input channel and on the output.
// The arbiter is combinational. One output register stage sustains one transfer per cycle.
module arb_mux #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_IN-1:0]               in_valid,
  input  logic [NUM_IN*WIDTH-1:0]         in_data,
  output logic [NUM_IN-1:0]               in_ready,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  output logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0] out_sel,
  input  logic                            out_ready
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              load_en;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  int unsigned       idx;

  assign load_en = !out_valid_q || out_ready;

  // Scan starts at ptr_q (round-robin) or at 0 (fixed priority). The first valid channel wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (load_en) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (ARB_MODE == 1) idx = j;
        else               idx = (int'(ptr_q) + j) % NUM_IN;
        if (!grant_any && in_valid[idx]) begin
          grant_any  = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any && ARB_MODE == 0) begin
      if (int'(grant_idx) == NUM_IN - 1) ptr_d = '0;
      else                               ptr_d = grant_idx + 1'b1;
    end
  end

  // in_ready is gated by rst_n so that no channel sees an accept while the block is held in reset.
  assign in_ready = rst_n ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else if (load_en) begin
      out_valid_q <= grant_any;
      ptr_q       <= ptr_d;
      if (grant_any) begin
        out_data_q <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_sel_q  <= grant_idx;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
